uart_rx: RTL and testbench



---
 rtl/uart_rx.sv | 181 ++++++++++++++++++
 tb/tb_uart_rx.sv | 295 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_rx.sv
// uart_rx: 16x-oversampled serial receiver for 1 start, NBits data (LSB first), 1 stop bit.
//
// Ports:
//   Clk      in   system clock, all logic on posedge
//   Rst      in   synchronous active-high reset
//   Tick     in   oversample enable, one-Clk pulse, OVS per bit time
//   Rx       in   asynchronous serial line, idle high
//   NBits    in   data bits per frame (5..8, others clamp to 8), latched at start confirm
//   RxData   out  received word, right-aligned, unused upper bits 0; holds until next frame
//   RxDone   out  one-Clk pulse: RxData valid, stop bit good
//   FrameErr out  one-Clk pulse: stop bit sampled low (RxData still loaded)
//   Busy     out  high whenever the receiver is not idle
//
// Optional build macro UART_RX_MAJORITY_EN: every mid-bit decision becomes the 2-of-3 majority
// of rx_s over three consecutive ticks, deciding one tick later than the single-sample build.

module uart_rx #(
    parameter int unsigned OVS         = 16,
    parameter int unsigned SYNC_STAGES = 2
) (
    input  logic       Clk,
    input  logic       Rst,
    input  logic       Tick,
    input  logic       Rx,
    input  logic [3:0] NBits,
    output logic [7:0] RxData,
    output logic       RxDone,
    output logic       FrameErr,
    output logic       Busy
);

    localparam int unsigned CW = $clog2(OVS);
    localparam logic [CW-1:0] CntLast = CW'(OVS - 1);
`ifdef UART_RX_MAJORITY_EN
    // Start decision waits for the third sample (mid+1); the cleared counter then runs one
    // tick behind the line, so data/stop decisions at OVS-1 cover line ticks mid-1..mid+1.
    localparam logic [CW-1:0] StartDec = CW'(OVS / 2);
`else
    localparam logic [CW-1:0] StartDec = CW'(OVS / 2 - 1);
`endif

    typedef enum logic [1:0] {StIdle, StStart, StData, StStop} state_t;

    state_t                 state_q, state_d;
    logic [SYNC_STAGES-1:0] sync_q;
    logic                   rx_d_q;
    logic                   rx_s;
    logic                   fall;
    logic                   bit_smp;
    logic [CW-1:0]          cnt_q, cnt_d;
    logic [2:0]             bitidx_q, bitidx_d;
    logic [3:0]             nb_q, nb_d;
    logic [7:0]             shreg_q, shreg_d;
    logic [7:0]             rx_data_q, rx_data_d;
    logic                   done_q, done_d;
    logic                   err_q, err_d;

    assign rx_s = sync_q[SYNC_STAGES-1];
    // Edge detect runs every Clk; only IDLE acts on it.
    assign fall = rx_d_q & ~rx_s;

    always_ff @(posedge Clk) begin
        if (Rst) begin
            sync_q <= '1;
            rx_d_q <= 1'b1;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], Rx};
            rx_d_q <= rx_s;
        end
    end

`ifdef UART_RX_MAJORITY_EN
    logic [1:0] hist_q;

    always_ff @(posedge Clk) begin
        if (Rst) begin
            hist_q <= 2'b11;
        end else if (Tick) begin
            hist_q <= {hist_q[0], rx_s};
        end
    end

    // The current rx_s is the third sample of the window.
    assign bit_smp = (hist_q[1] & hist_q[0]) | (hist_q[1] & rx_s) | (hist_q[0] & rx_s);
`else
    assign bit_smp = rx_s;
`endif

    always_ff @(posedge Clk) begin
        if (Rst) begin
            state_q   <= StIdle;
            cnt_q     <= '0;
            bitidx_q  <= '0;
            nb_q      <= 4'd8;
            shreg_q   <= '0;
            rx_data_q <= '0;
            done_q    <= 1'b0;
            err_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            bitidx_q  <= bitidx_d;
            nb_q      <= nb_d;
            shreg_q   <= shreg_d;
            rx_data_q <= rx_data_d;
            done_q    <= done_d;
            err_q     <= err_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        bitidx_d  = bitidx_q;
        nb_d      = nb_q;
        shreg_d   = shreg_q;
        rx_data_d = rx_data_q;
        done_d    = 1'b0;
        err_d     = 1'b0;
        unique case (state_q)
            StIdle: begin
                cnt_d = '0;
                if (fall) begin
                    state_d = StStart;
                end
            end
            StStart: begin
                if (Tick) begin
                    if (cnt_q == StartDec) begin
                        cnt_d = '0;
                        if (bit_smp) begin
                            state_d = StIdle;  // false start
                        end else begin
                            nb_d     = (NBits < 4'd5 || NBits > 4'd8) ? 4'd8 : NBits;
                            bitidx_d = '0;
                            shreg_d  = '0;
                            state_d  = StData;
                        end
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end
            end
            StData: begin
                if (Tick) begin
                    if (cnt_q == CntLast) begin
                        cnt_d = '0;
                        // Bit k lands at position k: right-aligned with zeros above nb.
                        shreg_d[bitidx_q] = bit_smp;
                        bitidx_d = bitidx_q + 3'd1;
                        if (bitidx_q == 3'(nb_q - 4'd1)) begin
                            state_d = StStop;
                        end
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end
            end
            StStop: begin
                if (Tick) begin
                    if (cnt_q == CntLast) begin
                        cnt_d     = '0;
                        rx_data_d = shreg_q;
                        done_d    = bit_smp;
                        err_d     = ~bit_smp;
                        state_d   = StIdle;
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end
            end
            default: state_d = StIdle;
        endcase
    end

    assign RxData   = rx_data_q;
    assign RxDone   = done_q;
    assign FrameErr = err_q;
    assign Busy     = (state_q != StIdle);

endmodule

// File: tb/tb_uart_rx.sv
// tb_uart_rx: self-checking bench for uart_rx. Tick pulses every 4 Clk; the line is driven in
// whole tick periods. Expected bytes, pulse kinds and latencies come from frame-level rules.

module tb_uart_rx;

    localparam int OVS = 16;
`ifdef UART_RX_MAJORITY_EN
    localparam int MAJ = 1;
`else
    localparam int MAJ = 0;
`endif

    logic       Clk = 1'b0;
    logic       Rst = 1'b1;
    logic       Tick = 1'b0;
    logic       Rx = 1'b1;
    logic [3:0] NBits = 4'd8;
    logic [7:0] RxData;
    logic       RxDone;
    logic       FrameErr;
    logic       Busy;

    int total = 0;
    int bad = 0;
    int period = 0;
    int viol = 0;
    logic prev_pulse = 1'b0;

    logic [1:0] ev_kind_q[$];  // 2'b01 done, 2'b10 frame error
    logic [7:0] ev_data_q[$];
    int         ev_per_q[$];

    uart_rx #(.OVS(OVS), .SYNC_STAGES(2)) dut (
        .Clk      (Clk),
        .Rst      (Rst),
        .Tick     (Tick),
        .Rx       (Rx),
        .NBits    (NBits),
        .RxData   (RxData),
        .RxDone   (RxDone),
        .FrameErr (FrameErr),
        .Busy     (Busy)
    );

    always #5 Clk = ~Clk;

    always @(negedge Clk) begin
        if (RxDone || FrameErr) begin
            ev_kind_q.push_back({FrameErr, RxDone});
            ev_data_q.push_back(RxData);
            ev_per_q.push_back(period);
        end
        if ((RxDone && FrameErr) || ((RxDone || FrameErr) && prev_pulse)) viol++;
        prev_pulse = RxDone || FrameErr;
    end

    // One tick period: line value applied with the Tick pulse, then three quiet Clks.
    task automatic tick_period(input logic val);
        @(posedge Clk); #1;
        Rx = val;
        Tick = 1'b1;
        period++;
        @(posedge Clk); #1;
        Tick = 1'b0;
        @(posedge Clk);
        @(posedge Clk); #1;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) tick_period(1'b1);
    endtask

    // Full frame; glitch pulls the line low for the one tick at each data bit's centre.
    task automatic send_frame(input logic [7:0] data, input int nb, input logic stop_val,
                              input logic glitch, input logic [3:0] nb_mid,
                              output int t0, output logic busy_mid);
        int   slot;
        logic v;
        t0 = period + 1;
        busy_mid = 1'b0;
        for (int p = 0; p < (nb + 2) * OVS; p++) begin
            slot = p / OVS;
            if (slot == 0) v = 1'b0;
            else if (slot <= nb) v = data[slot-1];
            else v = stop_val;
            if (glitch && slot >= 1 && slot <= nb && (p % OVS) == OVS / 2 - 1) v = 1'b0;
            if (p == 12) NBits = nb_mid;
            tick_period(v);
            if (p == 2 * OVS) busy_mid = Busy;
        end
    endtask

    function automatic int model_nb(input logic [3:0] n);
        return (n < 5 || n > 8) ? 8 : int'(n);
    endfunction

    function automatic int model_lat(input int nb);
        return OVS / 2 + (nb + 1) * OVS + MAJ;
    endfunction

    task automatic test_reset();
        Rst = 1'b1;
        Rx = 1'b1;
        repeat (3) @(posedge Clk);
        #1;
        total++;
        if (RxData !== 8'h00) begin bad++; $display("FAIL reset_rxdata: got %h want 00", RxData); end
        total++;
        if (RxDone !== 1'b0) begin bad++; $display("FAIL reset_rxdone: got %b want 0", RxDone); end
        total++;
        if (FrameErr !== 1'b0) begin bad++; $display("FAIL reset_ferr: got %b want 0", FrameErr); end
        total++;
        if (Busy !== 1'b0) begin bad++; $display("FAIL reset_busy: got %b want 0", Busy); end
        Rst = 1'b0;
        idle(4);
    endtask

    // Sends one good frame and checks pulse count, kind, data, latency and idle afterwards.
    task automatic test_good(input string name, input logic [7:0] data, input logic [3:0] nbits,
                             input logic glitch, input logic [7:0] exp);
        int t0, n0, nb, lat;
        logic bm;
        NBits = nbits;
        nb = model_nb(nbits);
        n0 = ev_kind_q.size();
        send_frame(data, nb, 1'b1, glitch, nbits, t0, bm);
        total++;
        if (bm !== 1'b1) begin bad++; $display("FAIL %s_busy_mid: got %b want 1", name, bm); end
        total++;
        if (ev_kind_q.size() - n0 != 1) begin
            bad++;
            $display("FAIL %s_count: got %0d pulses want 1", name, ev_kind_q.size() - n0);
        end else begin
            lat = ev_per_q[n0] - t0;
            total++;
            if (ev_kind_q[n0] !== 2'b01) begin
                bad++; $display("FAIL %s_kind: got %b want 01", name, ev_kind_q[n0]);
            end
            total++;
            if (ev_data_q[n0] !== exp) begin
                bad++; $display("FAIL %s_data: got %h want %h", name, ev_data_q[n0], exp);
            end
            total++;
            if (lat < model_lat(nb) - 1 || lat > model_lat(nb) + 1) begin
                bad++; $display("FAIL %s_latency: got %0d want %0d", name, lat, model_lat(nb));
            end
        end
        idle(2);
        total++;
        if (Busy !== 1'b0) begin bad++; $display("FAIL %s_busy_end: got %b want 0", name, Busy); end
    endtask

    task automatic test_basic();
        test_good("a5", 8'hA5, 4'd8, 1'b0, 8'hA5);
        test_good("nb5", 8'h16, 4'd5, 1'b0, 8'h16);
        test_good("nb4_clamp", 8'h3C, 4'd4, 1'b0, 8'h3C);
    endtask

    task automatic test_false_start();
        int n0;
        n0 = ev_kind_q.size();
        for (int i = 0; i < 4; i++) tick_period(1'b0);
        idle(24);
        total++;
        if (ev_kind_q.size() != n0) begin
            bad++; $display("FAIL false_start_pulse: got %0d pulses want 0", ev_kind_q.size() - n0);
        end
        total++;
        if (Busy !== 1'b0) begin bad++; $display("FAIL false_start_busy: got %b want 0", Busy); end
        test_good("after_false", 8'h5A, 4'd8, 1'b0, 8'h5A);
    endtask

    task automatic test_break();
        int t0, n0, lat;
        logic bm;
        NBits = 4'd8;
        n0 = ev_kind_q.size();
        send_frame(8'hFF, 8, 1'b0, 1'b0, 4'd8, t0, bm);
        for (int i = 0; i < 40; i++) tick_period(1'b0);
        idle(20);
        total++;
        if (ev_kind_q.size() - n0 != 1) begin
            bad++; $display("FAIL break_count: got %0d pulses want 1", ev_kind_q.size() - n0);
        end else begin
            lat = ev_per_q[n0] - t0;
            total++;
            if (ev_kind_q[n0] !== 2'b10) begin
                bad++; $display("FAIL break_kind: got %b want 10", ev_kind_q[n0]);
            end
            total++;
            if (ev_data_q[n0] !== 8'hFF) begin
                bad++; $display("FAIL break_data: got %h want ff", ev_data_q[n0]);
            end
            total++;
            if (lat < model_lat(8) - 1 || lat > model_lat(8) + 1) begin
                bad++; $display("FAIL break_latency: got %0d want %0d", lat, model_lat(8));
            end
        end
        total++;
        if (RxData !== 8'hFF) begin bad++; $display("FAIL break_hold: got %h want ff", RxData); end
        test_good("after_break", 8'h33, 4'd8, 1'b0, 8'h33);
    endtask

    task automatic test_reset_mid();
        int n0;
        logic [7:0] frame;
        logic rst_bad;
        frame = 8'h81;
        n0 = ev_kind_q.size();
        NBits = 4'd8;
        for (int p = 0; p < 40; p++) tick_period((p < OVS) ? 1'b0 : frame[p / OVS - 1]);
        Rst = 1'b1;
        Rx = 1'b1;
        rst_bad = 1'b0;
        @(posedge Clk);
        for (int i = 0; i < 6; i++) begin
            @(posedge Clk); #1;
            if (RxData !== 8'h00 || RxDone !== 1'b0 || FrameErr !== 1'b0 || Busy !== 1'b0)
                rst_bad = 1'b1;
        end
        total++;
        if (rst_bad !== 1'b0) begin
            bad++; $display("FAIL midreset_outputs: got nonzero outputs want all zero");
        end
        Rst = 1'b0;
        idle(6);
        total++;
        if (ev_kind_q.size() != n0) begin
            bad++; $display("FAIL midreset_pulse: got %0d pulses want 0", ev_kind_q.size() - n0);
        end
        test_good("after_reset", 8'h42, 4'd8, 1'b0, 8'h42);
    endtask

    task automatic test_glitch();
        test_good("glitch", 8'hFF, 4'd8, 1'b1, (MAJ != 0) ? 8'hFF : 8'h00);
    endtask

    // Random bytes and NBits (including out-of-range), NBits scrambled mid-frame, random gaps.
    task automatic test_random();
        int t0, n0, nb, lat;
        logic bm;
        logic [7:0] data, exp;
        logic [3:0] nbits;
        for (int f = 0; f < 16; f++) begin
            data = 8'($urandom);
            nbits = 4'($urandom_range(0, 15));
            NBits = nbits;
            nb = model_nb(nbits);
            exp = 8'(int'(data) % (1 << nb));
            idle($urandom_range(1, 5));
            n0 = ev_kind_q.size();
            send_frame(data, nb, 1'b1, 1'b0, 4'($urandom_range(0, 15)), t0, bm);
            total++;
            if (ev_kind_q.size() - n0 != 1) begin
                bad++;
                $display("FAIL rand%0d_count: got %0d pulses want 1", f, ev_kind_q.size() - n0);
            end else begin
                lat = ev_per_q[n0] - t0;
                total++;
                if (ev_kind_q[n0] !== 2'b01 || ev_data_q[n0] !== exp) begin
                    bad++;
                    $display("FAIL rand%0d_data: got kind %b data %h want kind 01 data %h", f,
                             ev_kind_q[n0], ev_data_q[n0], exp);
                end
                total++;
                if (lat < model_lat(nb) - 1 || lat > model_lat(nb) + 1) begin
                    bad++;
                    $display("FAIL rand%0d_latency: got %0d want %0d", f, lat, model_lat(nb));
                end
            end
        end
        idle(2);
    endtask

    task automatic test_pulse_rules();
        total++;
        if (viol != 0) begin
            bad++; $display("FAIL pulse_rules: got %0d violations want 0", viol);
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_false_start();
        test_break();
        test_reset_mid();
        test_glitch();
        test_random();
        test_pulse_rules();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
